lsu_mem_port: RTL and testbench
===============================

# lsu_mem_port

Load/store unit sitting between the execute stage and the data-memory bus. It takes the effective address computed by the ALU (base + imm), the store operand and the funct3 size code. It runs one request/acknowledge transaction on a word-wide memory port and returns a sign- or zero-extended load result. The pipeline is stalled through `busy` while a transaction is outstanding. A bus timeout and misaligned/illegal access detection report errors to the trap logic.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum cycles `mem_req` stays high without `mem_ack` before abort; legal range 1..255.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle launch strobe from execute; ignored while `busy`=1.
- `is_load`  in  1  access is a load.
- `is_store`  in  1  access is a store.
- `funct3`  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `addr`  in  32  effective byte address (ALU result).
- `store_data`  in  32  rs2 value.
- `busy`  out  1  stall request; high from the cycle after `start` until the cycle `done` is high, inclusive.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  valid with `done`; access faulted.
- `load_data`  out  32  extended load result; holds until the next successful load.
- `mem_req`  out  1  bus request, held until ack or timeout.
- `mem_we`  out  1  1 = write.
- `mem_addr`  out  32  word-aligned address (`addr[31:2]`, 2'b00).
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_be`  out  4  byte enables; all-ones for loads.
- `mem_ack`  in  1  bus acknowledge; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- FSM states: IDLE, REQ, FIN.
- IDLE, `start`=1: latch `is_load`, `is_store`, `funct3`, `addr`, `store_data`. Then check legality:
  - Illegal if `is_load`==`is_store`, `funct3` in {011,110,111}, or a store with `funct3[2]`=1. Illegal goes to FIN with err.
  - Otherwise go to REQ.
  - `start` with both flags 0 is also illegal, so every accepted `start` yields exactly one `done`.
- REQ: `mem_req`=1 and all bus outputs are stable.
  - `mem_ack`=1: capture `mem_rdata` for loads, go to FIN.
  - Timeout counter reaches TIMEOUT cycles with no ack: drop `mem_req`, go to FIN with err.
- FIN: `done`=1, `err` as determined, then return to IDLE.
- Store lanes:
  - SB: `mem_wdata`={4{sd[7:0]}}, `mem_be`=4'b0001<<addr[1:0].
  - SH: `mem_wdata`={2{sd[15:0]}}, `mem_be`= addr[1] ? 1100 : 0011.
  - SW: `mem_wdata`=sd, `mem_be`=1111.
- Loads: select the byte at `addr[1:0]` or the half at `addr[1]`, then sign-extend (B/H) or zero-extend (BU/HU). W passes the word through.
- `load_data` is updated only on a load finishing with err=0. Stores and errors leave it unchanged.

## Timing
- Reset (async, immediate): state IDLE. `busy`, `done`, `err`, `mem_req`, `mem_we` = 0. `mem_addr`, `mem_wdata`, `load_data` = 0. `mem_be`=0000. Timeout counter = 0.
- Reset during REQ drops `mem_req` immediately. No `done` is produced for the aborted access.
- `start` at edge N: `mem_req` high from cycle N+1.
- `mem_ack` sampled high at edge M gives `done` in cycle M+1. Minimum latency is `start`→`done` = 2 cycles (ack in the first REQ cycle).
- `mem_ack` while `mem_req`=0 is ignored.
- Timeout: `mem_req` high for exactly TIMEOUT cycles. An ack in the TIMEOUT-th cycle is accepted as success.
- Illegal access: `done`+`err` in cycle N+1, `mem_req` never asserted.
- `start` during FIN is ignored. A new access may launch the cycle after `done`.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses (H/HU/SH with addr[0]=1; W/SW with addr[1:0]≠0) are illegal.
  - They produce `done`+`err` at N+1 with no bus transaction.
- Undefined:
  - Misaligned accesses proceed with the offset forced to natural alignment (addr[0] cleared for H, addr[1:0] cleared for W).
  - No err.

## Test plan
- LB, addr=0x1003, `mem_rdata`=0x80FF_1234, ack on first REQ cycle → `mem_addr`=0x1000, `mem_be`=1111, `done` at cycle N+2, `load_data`=0xFFFF_FF80, err=0.
- SH, addr=0x2002, sd=0xDEAD_BEEF, ack after 3 cycles → `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF, `load_data` unchanged.
- LHU, addr=0x10, `mem_rdata`=0x8001_F00D → `load_data`=0x0000_F00D. The same access as LH gives 0xFFFF_F00D.
- LW with TIMEOUT=16 and no ack:
  - `mem_req` high exactly 16 cycles, then `done`+`err`.
  - Repeat with ack in cycle 16 → success.
- LW, addr=0x0000_0006:
  - With `LSU_MISALIGN_TRAP_EN`: `err` at N+1, `mem_req` never high.
  - Without it: `mem_addr`=0x4, no err.
- Extra `start` while busy, plus `rst_n` low mid-REQ:
  - The extra `start` is ignored (one `done` only).
  - On reset, `mem_req`/`busy` drop immediately and no `done` follows.

Source files
------------

// File: rtl/lsu_mem_port.sv
// Load/store unit bus port: one req/ack word transaction per access, with lane steering,
// load extension, a bus timeout and illegal-access detection. Optional macro LSU_MISALIGN_TRAP_EN.
module lsu_mem_port #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] load_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);
    typedef enum logic [1:0] {IDLE, REQ, FIN} state_t;

    state_t      state, state_nx;
    logic [7:0]  tcnt;
    logic        err_q;
    logic        lat_load;
    logic [2:0]  lat_f3;
    logic [1:0]  lat_off;
    logic        illegal;
    logic [1:0]  off_eff;
    logic [3:0]  be_nx;
    logic [31:0] wdata_nx;
    logic        tmo;

    assign busy    = (state != IDLE);
    assign done    = (state == FIN);
    assign err     = done & err_q;
    assign mem_req = (state == REQ);
    assign tmo     = (tcnt == 8'(TIMEOUT - 1));

    always_comb begin
        illegal = (is_load == is_store) || (funct3 == 3'b011) || (funct3[2:1] == 2'b11) ||
                  (is_store && funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00))
            illegal = 1'b1;
`endif
    end

    // Without the trap, misaligned halves/words are silently snapped to natural alignment.
    always_comb begin
        case (funct3[1:0])
            2'b00:   off_eff = addr[1:0];
            2'b01:   off_eff = {addr[1], 1'b0};
            default: off_eff = 2'b00;
        endcase
    end

    always_comb begin
        be_nx    = 4'b1111;
        wdata_nx = store_data;
        if (is_store) begin
            case (funct3[1:0])
                2'b00: begin
                    be_nx    = 4'b0001 << off_eff;
                    wdata_nx = {4{store_data[7:0]}};
                end
                2'b01: begin
                    be_nx    = off_eff[1] ? 4'b1100 : 4'b0011;
                    wdata_nx = {2{store_data[15:0]}};
                end
                default: ;
            endcase
        end
    end

    function automatic logic [31:0] ext_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b100:  return {24'b0, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'b0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = illegal ? FIN : REQ;
            REQ:  if (mem_ack || tmo) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tcnt      <= 8'd0;
            err_q     <= 1'b0;
            lat_load  <= 1'b0;
            lat_f3    <= 3'b000;
            lat_off   <= 2'b00;
            load_data <= 32'd0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'b0000;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (start) begin
                    lat_load  <= is_load;
                    lat_f3    <= funct3;
                    lat_off   <= off_eff;
                    err_q     <= illegal;
                    tcnt      <= 8'd0;
                    mem_we    <= is_store;
                    mem_addr  <= {addr[31:2], 2'b00};
                    mem_wdata <= wdata_nx;
                    mem_be    <= be_nx;
                end
                REQ: begin
                    if (mem_ack) begin
                        err_q <= 1'b0;
                        if (lat_load) load_data <= ext_load(lat_f3, lat_off, mem_rdata);
                    end else begin
                        tcnt <= tcnt + 8'd1;
                        if (tmo) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized self-checking bench for lsu_mem_port against a per-access reference model.
module tb_lsu_mem_port;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, is_load = 1'b0, is_store = 1'b0;
    logic [2:0]  funct3 = 3'b0;
    logic [31:0] addr = 32'd0, store_data = 32'd0;
    logic        busy, done, err, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int          vecs = 0, errs = 0;
    logic [31:0] exp_ld = 32'd0;

    lsu_mem_port #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data), .busy(busy), .done(done),
        .err(err), .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One access: ackc = REQ cycle (1-based) in which the bus acks, 0 = never.
    // poke re-asserts start with junk during the first REQ cycle.
    task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rd, input int ackc, input bit poke);
        bit ill, mis, succ, seen;
        logic [1:0] off;
        logic [3:0] eb;
        logic [31:0] ew, el, sh;
        int nreq_exp, nreq, lat;
        mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        ill = (ld == st) || f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (st && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        ill = ill || mis;
`endif
        off = (f3[1:0] == 2'b00) ? a[1:0] : (f3[1:0] == 2'b01) ? {a[1], 1'b0} : 2'b00;
        if (ld)                    eb = 4'hF;
        else if (f3[1:0] == 2'b00) eb = 4'b0001 << off;
        else if (f3[1:0] == 2'b01) eb = off[1] ? 4'b1100 : 4'b0011;
        else                       eb = 4'hF;
        ew = (f3[1:0] == 2'b00) ? {4{sd[7:0]}} : (f3[1:0] == 2'b01) ? {2{sd[15:0]}} : sd;
        sh = rd / (32'd1 << (8 * off));
        case (f3)
            3'd0:    el = {{24{sh[7]}}, sh[7:0]};
            3'd4:    el = {24'd0, sh[7:0]};
            3'd1:    el = {{16{sh[15]}}, sh[15:0]};
            3'd5:    el = {16'd0, sh[15:0]};
            default: el = rd;
        endcase
        succ = !ill && ackc >= 1 && ackc <= TO;
        nreq_exp = ill ? 0 : (succ ? ackc : TO);

        @(negedge clk);
        start = 1'b1; is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
        mem_ack = $urandom_range(0, 1);  // ack while idle must be ignored
        @(negedge clk);
        start = 1'b0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom);
        lat = 1; nreq = 0; seen = 0;
        for (int c = 0; c < TO + 6 && !seen; c++) begin
            if (done) begin
                seen = 1;
                start = 1'b0; mem_ack = 1'b0;
                chk("latency", lat, ill ? 1 : nreq_exp + 1);
                chk("err", err, !succ);
                chk("busy_at_done", busy, 1);
                chk("req_cycles", nreq, nreq_exp);
                if (ld && succ) exp_ld = el;
                chk("load_data", load_data, exp_ld);
            end else begin
                chk("busy", busy, 1);
                start = 1'b0;
                mem_ack = 1'b0;
                if (mem_req) begin
                    nreq++;
                    chk("mem_addr", mem_addr, {a[31:2], 2'b00});
                    chk("mem_we", mem_we, st);
                    chk("mem_be", mem_be, eb);
                    if (st) chk("mem_wdata", mem_wdata, ew);
                    if (poke && nreq == 1) begin
                        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2;
                    end
                    mem_ack = (nreq == ackc);
                    mem_rdata = (nreq == ackc) ? rd : $urandom;
                end
                @(negedge clk);
                lat++;
            end
        end
        chk("done_seen", seen, 1);
        start = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk("done_after", done, 0);
        chk("idle_after", busy, 0);
    endtask

    initial begin
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_req", mem_req, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", mem_be, 0);
        chk("rst_ld", load_data, 0);
        @(negedge clk);
        rst_n = 1'b1;

        txn(1, 0, 3'd0, 32'h1003, 32'h0, 32'h80FF_1234, 1, 0);          // LB
        chk("lb_value", load_data, 32'hFFFF_FF80);
        txn(0, 1, 3'd1, 32'h2002, 32'hDEAD_BEEF, 32'h0, 3, 0);          // SH
        chk("sh_keeps_ld", load_data, 32'hFFFF_FF80);
        txn(1, 0, 3'd5, 32'h10, 32'h0, 32'h8001_F00D, 1, 0);            // LHU
        chk("lhu_value", load_data, 32'h0000_F00D);
        txn(1, 0, 3'd1, 32'h10, 32'h0, 32'h8001_F00D, 2, 0);            // LH
        chk("lh_value", load_data, 32'hFFFF_F00D);
        txn(1, 0, 3'd2, 32'h40, 32'h0, 32'h1234_5678, 0, 0);            // LW timeout
        txn(1, 0, 3'd2, 32'h40, 32'h0, 32'h1234_5678, TO, 0);           // ack in last cycle
        txn(1, 0, 3'd2, 32'h6, 32'h0, 32'hCAFE_0001, 1, 0);             // misaligned LW
        txn(1, 0, 3'd2, 32'h80, 32'h0, 32'h5555_AAAA, 2, 1);            // start while busy
        txn(0, 0, 3'd2, 32'h80, 32'h0, 32'h0, 1, 0);                    // no flags
        txn(1, 1, 3'd2, 32'h80, 32'h0, 32'h0, 1, 0);                    // both flags
        txn(1, 0, 3'd3, 32'h80, 32'h0, 32'h0, 1, 0);                    // bad funct3
        txn(0, 1, 3'd4, 32'h80, 32'h11, 32'h0, 1, 0);                   // SBU
        txn(0, 1, 3'd0, 32'h83, 32'hA5, 32'h0, 1, 0);                   // SB lane 3

        for (int i = 0; i < 300; i++) begin
            int r, ac;
            bit ld, st;
            r = $urandom_range(0, 9);
            if (r == 0) begin ld = $urandom_range(0, 1); st = ld; end
            else begin ld = (r < 6); st = !ld; end
            ac = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + 2) : $urandom_range(1, 4);
            txn(ld, st, 3'($urandom), $urandom, $urandom, $urandom, ac, $urandom_range(0, 7) == 0);
        end

        // Reset in the middle of a bus request
        @(negedge clk);
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h100;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_req", mem_req, 0);
        chk("rst_drop_busy", busy, 0);
        chk("rst_clr_ld", load_data, 0);
        exp_ld = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("no_done_after_rst", done, 0);
        end
        txn(1, 0, 3'd4, 32'h201, 32'h0, 32'h0000_9A00, 1, 0);
        chk("post_rst_lbu", load_data, 32'h0000_009A);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
